// File: rtl/memory_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_pkg
// Description : Shared types and constants for the MIPS memory stage:
//               data-memory handshake FSM states and MemtoReg bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_stage_pkg;

    // Data-memory handshake FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } hs_state_t;

    // MemtoReg field layout, shared with execute and writeback
    localparam int          c_MTR_WIDTH = 4;
    localparam int          c_MTR_LOAD  = 0;        // bit set => instruction is a load
    localparam logic [3:0]  c_MTR_RESET = 4'b1110;  // reset value, load bit clear

    localparam int          c_CNT_WIDTH = 8;        // wait-state counter width

endpackage : memory_stage_pkg
`default_nettype wire

// File: rtl/memory_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_if
// Description : Request/acknowledge bus between the memory stage (master)
//               and data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface : memory_stage_if
`default_nettype wire

// File: rtl/memory_stage_dmem_handshake.sv
`default_nettype none
// ============================================================================
// Module      : dmem_handshake
// Description : Wait-state FSM for data-memory accesses with bus timeout,
//               stall generation and one-cycle error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_handshake
    import memory_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  wire logic clk,
    input  wire logic rst,          // asynchronous, active-low
    input  wire logic i_memop,
    input  wire logic i_misal,
    input  wire logic i_ack,
    output logic      o_req,
    output logic      o_stall,
    output logic      o_complete,   // acknowledged access this cycle
    output logic      o_abort,      // timed-out access this cycle (BusErr)
    output logic      o_adr_err
);

    localparam logic [c_CNT_WIDTH-1:0] c_TIMEOUT = c_CNT_WIDTH'(TIMEOUT);

    hs_state_t              r_state;
    hs_state_t              w_next;
    logic [c_CNT_WIDTH-1:0] r_cnt;
    logic [c_CNT_WIDTH-1:0] w_cnt_next;

    // Next-state, counter and output decode; the IDLE cycle with a pending
    // request counts as the first wait so a timeout costs TIMEOUT stalls.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = '0;
        o_req      = 1'b0;
        o_abort    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                o_req = i_memop & ~i_misal;
                if (o_req && !i_ack) begin
                    w_next     = ST_WAIT;
                    w_cnt_next = c_CNT_WIDTH'(1);
                end
            end
            ST_WAIT: begin
                o_req   = 1'b1;
                // an ack in the timeout cycle wins over the abort
                o_abort = ~i_ack & (r_cnt == c_TIMEOUT);
                if (i_ack || o_abort) begin
                    w_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_WIDTH'(1);
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        o_complete = o_req & i_ack;
        o_stall    = o_req & ~i_ack & ~o_abort;
        o_adr_err  = i_misal;
    end

    // State and wait counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

endmodule : dmem_handshake
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : MIPS pipeline memory stage: E/M pipeline register, data
//               memory request/acknowledge handshake and load-data capture.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  wire logic                   clk,
    input  wire logic                   rst,        // asynchronous, active-low
    input  wire logic                   jumpE,
    input  wire logic                   RegWriteE,
    input  wire logic                   MemWriteE,
    input  wire logic [c_MTR_WIDTH-1:0] MemtoRegE,
    input  wire logic [4:0]             WriteRegE,
    input  wire logic [31:0]            ALUMultOutE,
    input  wire logic [31:0]            WriteDataE,
    input  wire logic [31:0]            PCPlus4E,
    output logic                        jumpM,
    output logic                        RegWriteM,
    output logic [c_MTR_WIDTH-1:0]      MemtoRegM,
    output logic [4:0]                  WriteRegM,
    output logic [31:0]                 ALUOutM,
    output logic [31:0]                 PCPlus4M,
    output logic [31:0]                 ReadDataW,
    output logic                        MemStallM,
    output logic                        AdrErrM,
    output logic                        BusErrM,
    memory_stage_if.master              dmem
);

    logic                   r_jump;
    logic                   r_reg_write;
    logic                   r_mem_write;
    logic [c_MTR_WIDTH-1:0] r_memtoreg;
    logic [4:0]             r_write_reg;
    logic [31:0]            r_alu_out;
    logic [31:0]            r_write_data;
    logic [31:0]            r_pc_plus4;
    logic [31:0]            r_read_data;

    logic w_memop;
    logic w_misal;
    logic w_req;
    logic w_stall;
    logic w_complete;
    logic w_abort;
    logic w_adr_err;

    assign w_memop = r_mem_write | r_memtoreg[c_MTR_LOAD];
    assign w_misal = w_memop & (r_alu_out[1:0] != 2'b00);

    dmem_handshake #(
        .TIMEOUT (TIMEOUT)
    ) u_handshake (
        .clk        (clk),
        .rst        (rst),
        .i_memop    (w_memop),
        .i_misal    (w_misal),
        .i_ack      (dmem.dmem_ack),
        .o_req      (w_req),
        .o_stall    (w_stall),
        .o_complete (w_complete),
        .o_abort    (w_abort),
        .o_adr_err  (w_adr_err)
    );

    // E/M pipeline register, held while an access is outstanding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_jump       <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_memtoreg   <= c_MTR_RESET;
            r_write_reg  <= '0;
            r_alu_out    <= '0;
            r_write_data <= '0;
            r_pc_plus4   <= '0;
        end else if (!w_stall) begin
            r_jump       <= jumpE;
            r_reg_write  <= RegWriteE;
            r_mem_write  <= MemWriteE;
            r_memtoreg   <= MemtoRegE;
            r_write_reg  <= WriteRegE;
            r_alu_out    <= ALUMultOutE;
            r_write_data <= WriteDataE;
            r_pc_plus4   <= PCPlus4E;
        end
    end

    // Load data for W: memory data on a completed load, zero on a failed access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_read_data <= '0;
        end else if (w_complete && r_memtoreg[c_MTR_LOAD]) begin
            r_read_data <= dmem.dmem_rdata;
        end else if (w_abort || w_misal) begin
            r_read_data <= '0;
        end
    end

    assign jumpM           = r_jump;
    assign RegWriteM       = r_reg_write;
    assign MemtoRegM       = r_memtoreg;
    assign WriteRegM       = r_write_reg;
    assign ALUOutM         = r_alu_out;
    assign PCPlus4M        = r_pc_plus4;
    assign ReadDataW       = r_read_data;
    assign MemStallM       = w_stall;
    assign AdrErrM         = w_adr_err;
    assign BusErrM         = w_abort;

    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = r_mem_write & w_req;
    assign dmem.dmem_addr  = {r_alu_out[31:2], 2'b00};
    assign dmem.dmem_wdata = r_write_data;

endmodule : memory_stage
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage
// Description : Directed self-checking bench for memory_stage (TIMEOUT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        jumpE, RegWriteE, MemWriteE;
    logic [3:0]  MemtoRegE;
    logic [4:0]  WriteRegE;
    logic [31:0] ALUMultOutE, WriteDataE, PCPlus4E;
    logic        jumpM, RegWriteM;
    logic [3:0]  MemtoRegM;
    logic [4:0]  WriteRegM;
    logic [31:0] ALUOutM, PCPlus4M, ReadDataW;
    logic        MemStallM, AdrErrM, BusErrM;

    int n_vec = 0;
    int n_err = 0;
    int stall_cnt;
    int berr_cnt;

    memory_stage_if u_if ();

    memory_stage #(
        .TIMEOUT (4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .jumpE       (jumpE),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .MemtoRegE   (MemtoRegE),
        .WriteRegE   (WriteRegE),
        .ALUMultOutE (ALUMultOutE),
        .WriteDataE  (WriteDataE),
        .PCPlus4E    (PCPlus4E),
        .jumpM       (jumpM),
        .RegWriteM   (RegWriteM),
        .MemtoRegM   (MemtoRegM),
        .WriteRegM   (WriteRegM),
        .ALUOutM     (ALUOutM),
        .PCPlus4M    (PCPlus4M),
        .ReadDataW   (ReadDataW),
        .MemStallM   (MemStallM),
        .AdrErrM     (AdrErrM),
        .BusErrM     (BusErrM),
        .dmem        (u_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_e(input logic j, input logic rw, input logic mw, input logic [3:0] mtr,
                         input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pc);
        jumpE       = j;
        RegWriteE   = rw;
        MemWriteE   = mw;
        MemtoRegE   = mtr;
        WriteRegE   = wr;
        ALUMultOutE = alu;
        WriteDataE  = wd;
        PCPlus4E    = pc;
    endtask

    task automatic nop();
        set_e(1'b0, 1'b0, 1'b0, 4'b0000, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        nop();
        u_if.dmem_ack   = 1'b0;
        u_if.dmem_rdata = 32'h0;

        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_memtoreg", 32'(MemtoRegM), 32'hE);
        check("rst_req",      32'(u_if.dmem_req), 32'h0);
        check("rst_stall",    32'(MemStallM), 32'h0);
        check("rst_readdata", ReadDataW, 32'h0);
        check("rst_aluout",   ALUOutM, 32'h0);
        check("rst_errs",     {30'h0, AdrErrM, BusErrM}, 32'h0);
        tick();
        rst = 1'b1;

        // ---------------- zero-wait load ----------------
        set_e(1'b1, 1'b1, 1'b0, 4'b0001, 5'd5, 32'h100, 32'h0, 32'h40);
        u_if.dmem_ack   = 1'b1;
        u_if.dmem_rdata = 32'hDEADBEEF;
        tick();
        nop();
        @(negedge clk);
        check("zw_req",    32'(u_if.dmem_req), 32'h1);
        check("zw_stall",  32'(MemStallM), 32'h0);
        check("zw_we",     32'(u_if.dmem_we), 32'h0);
        check("zw_addr",   u_if.dmem_addr, 32'h100);
        check("zw_wreg",   32'(WriteRegM), 32'd5);
        check("zw_flags",  {30'h0, jumpM, RegWriteM}, 32'h3);
        check("zw_pc",     PCPlus4M, 32'h40);
        tick();
        u_if.dmem_ack = 1'b0;
        @(negedge clk);
        check("zw_rdata",  ReadDataW, 32'hDEADBEEF);
        check("zw_req_dn", 32'(u_if.dmem_req), 32'h0);

        // ------- store with 3 wait states, back-to-back load -------
        set_e(1'b0, 1'b0, 1'b1, 4'b0000, 5'd0, 32'h204, 32'h12345678, 32'h80);
        tick();
        set_e(1'b0, 1'b1, 1'b0, 4'b0001, 5'd7, 32'h208, 32'h0, 32'h84);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("st_stall", 32'(MemStallM), 32'h1);
            check("st_we",    32'(u_if.dmem_we), 32'h1);
            check("st_hold",  ALUOutM, 32'h204);
            tick();
        end
        u_if.dmem_ack   = 1'b1;
        u_if.dmem_rdata = 32'h11112222;
        @(negedge clk);
        check("st_ack_stall", 32'(MemStallM), 32'h0);
        check("st_wdata",     u_if.dmem_wdata, 32'h12345678);
        check("st_rd_hold",   ReadDataW, 32'hDEADBEEF);
        tick();
        nop();
        @(negedge clk);
        check("b2b_alu",  ALUOutM, 32'h208);
        check("b2b_req",  32'(u_if.dmem_req), 32'h1);
        check("b2b_we",   32'(u_if.dmem_we), 32'h0);
        check("b2b_wreg", 32'(WriteRegM), 32'd7);
        tick();
        u_if.dmem_ack = 1'b0;
        @(negedge clk);
        check("b2b_rdata", ReadDataW, 32'h11112222);

        // ---------------- misaligned load ----------------
        set_e(1'b0, 1'b1, 1'b0, 4'b0001, 5'd8, 32'h102, 32'h0, 32'h90);
        tick();
        nop();
        @(negedge clk);
        check("mis_adrerr", 32'(AdrErrM), 32'h1);
        check("mis_req",    32'(u_if.dmem_req), 32'h0);
        check("mis_stall",  32'(MemStallM), 32'h0);
        tick();
        @(negedge clk);
        check("mis_rdata",  ReadDataW, 32'h0);
        check("mis_pulse",  32'(AdrErrM), 32'h0);

        // ------- ack arriving on the timeout cycle -------
        set_e(1'b0, 1'b1, 1'b0, 4'b0001, 5'd9, 32'h400, 32'h0, 32'hA0);
        tick();
        nop();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ackto_stall", 32'(MemStallM), 32'h1);
            tick();
        end
        u_if.dmem_ack   = 1'b1;
        u_if.dmem_rdata = 32'h0BADF00D;
        @(negedge clk);
        check("ackto_buserr", 32'(BusErrM), 32'h0);
        check("ackto_stall0", 32'(MemStallM), 32'h0);
        tick();
        u_if.dmem_ack = 1'b0;
        @(negedge clk);
        check("ackto_rdata", ReadDataW, 32'h0BADF00D);

        // ---------------- timeout, no ack ----------------
        u_if.dmem_rdata = 32'hCAFEF00D;
        set_e(1'b0, 1'b1, 1'b0, 4'b0001, 5'd10, 32'h300, 32'h0, 32'hB0);
        tick();
        nop();
        stall_cnt = 0;
        berr_cnt  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (BusErrM) berr_cnt++;
            if (!MemStallM) break;
            stall_cnt++;
            tick();
        end
        check("to_stalls", 32'(stall_cnt), 32'd4);
        check("to_buserr", 32'(berr_cnt), 32'd1);
        tick();
        @(negedge clk);
        check("to_rdata",   ReadDataW, 32'h0);
        check("to_pulse",   32'(BusErrM), 32'h0);
        check("to_req_dn",  32'(u_if.dmem_req), 32'h0);

        // ---------------- reset in the middle of WAIT ----------------
        set_e(1'b0, 1'b1, 1'b0, 4'b0001, 5'd3, 32'h500, 32'h0, 32'hC0);
        tick();
        nop();
        tick();
        tick();
        @(negedge clk);
        check("rw_stall_pre", 32'(MemStallM), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("rw_req",      32'(u_if.dmem_req), 32'h0);
        check("rw_stall",    32'(MemStallM), 32'h0);
        check("rw_memtoreg", 32'(MemtoRegM), 32'hE);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rw_mtr_hold", 32'(MemtoRegM), 32'hE);
        tick();
        @(negedge clk);
        check("rw_mtr_load", 32'(MemtoRegM), 32'h0);
        check("rw_req_post", 32'(u_if.dmem_req), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_memory_stage
`default_nettype wire

// File: doc/memory_stage.md
# memory_stage

Pipeline memory stage of the five-stage MIPS core, sitting directly downstream of the execute stage. It holds the E/M pipeline register and drives the forwarding value `ALUOutM` back to execute. It also runs a request/acknowledge handshake to data memory, with a wait-state FSM and a bus timeout. While a data access is outstanding it stalls the pipeline through the hazard unit.

## Interface
- `TIMEOUT`, 255: maximum cycles spent in WAIT before the access is aborted (1..255).
- `clk` input 1: the single clock. All state changes on its rising edge.
- `rst` input 1: reset. Asynchronous, active-low.
- `jumpE`, `RegWriteE`, `MemWriteE` input 1 each: control flags from execute.
- `MemtoRegE` input 4: result-select flags. Bit 0 = 1 marks a load.
- `WriteRegE` input 5: destination register.
- `ALUMultOutE`, `WriteDataE`, `PCPlus4E` input 32 each: data from execute.
- `jumpM`, `RegWriteM` output 1 each: registered flags, forwarded to writeback.
- `MemtoRegM` output 4: registered result-select flags.
- `WriteRegM` output 5: registered destination register, also sent to the hazard unit.
- `ALUOutM` output 32: registered `ALUMultOutE`. Drives forwarding and the memory address.
- `PCPlus4M` output 32: registered `PCPlus4E`.
- `ReadDataW` output 32: load data, captured on the completing edge of the access.
- `MemStallM` output 1: to hazard unit. While high, the stages upstream of M and the M register all hold.
- `AdrErrM`, `BusErrM` output 1 each: one-cycle error pulses.
- `dmem_req` output 1: memory request.
- `dmem_we` output 1: write enable.
- `dmem_addr` output 32: memory address, equal to `{ALUOutM[31:2],2'b00}`.
- `dmem_wdata` output 32: write data.
- `dmem_ack` input 1: memory acknowledge.
- `dmem_rdata` input 32: memory read data, valid with `dmem_ack`.

## Operation
- M register fields: `jump`, `RegWrite`, `MemWrite`, `MemtoReg`, `WriteReg`, `ALUOut`, `WriteData`, `PCPlus4`.
  - Loads from the E outputs on each rising edge where `MemStallM` = 0.
  - Holds when `MemStallM` = 1.
- Decoded terms:
  - `memop` = `MemWriteM | MemtoRegM[0]`.
  - `misal` = `memop & (ALUOutM[1:0] != 0)`.
- Misaligned access (`misal` = 1):
  - No request is issued and there is no stall.
  - `AdrErrM` = 1 for the cycle.
  - `ReadDataW` loads 0 at the next edge.
- FSM state IDLE:
  - `dmem_req` = `memop & !misal`.
  - `dmem_ack` = 1 in the same cycle completes the access with zero wait states.
  - Otherwise, if a request is pending, move to WAIT.
- FSM state WAIT:
  - `dmem_req` = 1.
  - The wait counter increments each cycle.
  - `dmem_ack` completes the access and returns to IDLE.
  - Counter reaching `TIMEOUT` aborts the access, returns to IDLE and gives `BusErrM` = 1 for that cycle. An aborted access is treated as completed with data 0.
- `MemStallM` = `dmem_req & !dmem_ack & !abort`.
- Each access gets exactly one acknowledge; the request drops in the cycle after completion.
- `dmem_we` = `MemWriteM & dmem_req`.
- `dmem_wdata` = `WriteDataM`.
- `ReadDataW`:
  - Loads `dmem_rdata` on a completing edge of a load.
  - Loads 0 on abort or misaligned access.
  - Holds otherwise.
- Simultaneous `dmem_ack` and timeout in the same cycle: the ack wins and `BusErrM` stays 0.
- `RegWriteM` passes through unchanged. Writeback qualifies it with the error flags.

## Timing
- Reset values:
  - All M fields 0, except `MemtoRegM` = 4'b1110.
  - `ReadDataW` 0.
  - FSM IDLE, counter 0.
  - All outputs 0 (`dmem_req` 0, `MemStallM` 0, error flags 0).
- Reset mid-access: `dmem_req` drops immediately (asynchronously). No completion is reported.
- Latency: E-to-M is one cycle. `ReadDataW` becomes valid one cycle after the completing cycle, aligned with the instruction's W stage.
- Stall cycles per access: N cycles of wait gives N stall cycles. Timeout gives exactly `TIMEOUT` stall cycles.
- Back-to-back accesses: the next instruction enters M on the completing edge and may request in the very next cycle. There is no bubble.
- Counter is 8 bits and clears on every return to IDLE. It never wraps.

## Structure
- Shared package: the FSM state enum (IDLE, WAIT) and the `MemtoReg` bit-position constants, as used by execute and writeback.
- One sub-module, `dmem_handshake`: the FSM, the timeout counter and the error pulses. The top level holds the M register and `ReadDataW`.

## Test plan
- Reset mid-WAIT: `rst` low during WAIT → `dmem_req`, `MemStallM` = 0 immediately; `MemtoRegM` = 4'b1110 until the next non-stalled edge.
- Zero-wait load: `ALUMultOutE`=0x100, `dmem_ack` tied 1, `dmem_rdata`=0xDEADBEEF → `dmem_req` for 1 cycle; `MemStallM` never high; `ReadDataW`=0xDEADBEEF on the next cycle.
- Store with 3 wait states: `MemWriteE`=1, addr 0x204, `WriteDataE`=0x12345678 → `dmem_we`=1 and `MemStallM`=1 for 3 cycles; M fields hold; the next instruction loads on the ack edge.
- Misaligned load at 0x102 → `AdrErrM` pulse, `dmem_req` stays 0, `ReadDataW`=0, no stall.
- Timeout with `TIMEOUT`=4, ack never arrives → exactly 4 stall cycles, `BusErrM` pulses once, `ReadDataW`=0.
- Ack on the same cycle the counter reaches `TIMEOUT` → data captured, `BusErrM`=0.
